store_result_monitor: RTL
=========================

Name: store_result_monitor

Overview:
- Synthesizable on-chip checker directly downstream of the processor top.
- Consumes the processor's data-memory write bus (memwrite, dataadr, writedata) every cycle and decides pass/fail for a test program.
- Pass condition: the program stores the signature value to the result address.
- Fail conditions: any other store address, or no result within a cycle budget.
- Drives sticky done/pass/fail flags, a fail code and capture registers for LEDs or debug readout.

Parameters:
- PASS_ADDR, 32'd84, store address that ends the test.
- PASS_DATA, 32'd7, data required at PASS_ADDR for a pass.
- ALLOW_ADDR, 32'd80, the only other address the program may store to.
- TIMEOUT, 1000, cycles in RUN before declaring timeout fail; must be ≥1.
- CNT_W, 16, width of the cycle and store counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; 0 sampled at a rising edge resets the block.
- memwrite  in  1  processor store strobe; one store per cycle when high.
- dataadr  in  32  processor store address, valid when memwrite=1.
- writedata  in  32  processor store data, valid when memwrite=1.
- done  out  1  high once a verdict is reached (PASS or FAIL state).
- pass  out  1  verdict pass.
- fail  out  1  verdict fail.
- fail_code  out  2  0 none, 1 bad address, 2 wrong data at PASS_ADDR, 3 timeout.
- store_count  out  CNT_W  stores observed in RUN; saturates at all-ones.
- cap_addr  out  32  address of the verdict-causing store; 0 for timeout.
- cap_data  out  32  data of the verdict-causing store; 0 for timeout.

Behaviour:
- Reset (reset=0 at a rising edge):
  - State goes to RUN.
  - done, pass, fail, fail_code, store_count, cap_addr, cap_data and the internal cycle counter all clear to 0.
  - Reset overrides any simultaneous store; reset mid-test or after a verdict restarts the check cleanly.
- States:
  - RUN (after reset): evaluated each rising edge with reset=1.
    - memwrite=1, dataadr==PASS_ADDR, writedata==PASS_DATA -> PASS.
    - memwrite=1, dataadr==PASS_ADDR, writedata!=PASS_DATA -> FAIL, code 2.
    - memwrite=1, dataadr==ALLOW_ADDR -> stay in RUN; any data accepted; store_count+1.
    - memwrite=1, any other address -> FAIL, code 1.
    - memwrite=0 -> stay in RUN.
    - Cycle counter increments every RUN cycle. On the edge where it reaches TIMEOUT-1 with no store verdict -> FAIL, code 3.
  - PASS / FAIL: terminal and sticky until reset. All inputs ignored; counters frozen.
- Latency: verdict outputs update at the same rising edge that samples the deciding store (one-edge registered latency). No combinational path from inputs to outputs.
- Capture: on a store verdict, cap_addr/cap_data load the sampled dataadr/writedata.
- store_count:
  - Counts every store sampled in RUN, including the verdict-causing store.
  - Saturates at 2^CNT_W-1; no wrap.
- Simultaneous events: a store verdict and the timeout on the same edge -> the store verdict wins (code 0/1/2, not 3).
- ALLOW_ADDR==PASS_ADDR: the PASS_ADDR rules take priority.
- Outputs are one-hot consistent: pass and fail are never both 1; done = pass | fail; fail_code is 0 whenever fail=0.

Test Plan:
- Stores 80<-3, 80<-5, then 84<-7 on consecutive cycles -> pass=1, done=1, fail_code=0, store_count=3, cap_addr=84, cap_data=7 after the third edge; flags stay set for 20 further cycles with random stores.
- Store 84<-6 -> fail=1, fail_code=2, cap_addr=84, cap_data=6, store_count=1.
- Store 80<-1, then 88<-7 -> fail=1, fail_code=1, cap_addr=88, store_count=2.
- TIMEOUT=10, memwrite held 0 -> fail=1, fail_code=3 exactly at the 10th edge after reset release; cap_addr=0, cap_data=0.
- TIMEOUT=4, store 84<-7 on the 4th RUN edge -> pass=1, fail_code=0 (store beats timeout).
- Drive reset=0 for one edge after a fail, then stores 80<-2 and 84<-7 -> all outputs clear, then pass=1 with store_count=2.
- Same reset pulse applied mid-RUN with memwrite=1, dataadr=99 -> no fail is recorded.

Source files
------------

// File: rtl/store_result_monitor.sv
// store_result_monitor
// Watches the processor's data-memory write bus and reaches a sticky pass/fail
// verdict for a self-checking test program. A store of PASS_DATA to PASS_ADDR
// passes. Any store to an address other than PASS_ADDR or ALLOW_ADDR fails.
// A wrong value stored at PASS_ADDR fails. Running for TIMEOUT cycles without a
// verdict also fails. All outputs come straight from registers.
module store_result_monitor #(
    parameter logic [31:0] PASS_ADDR  = 32'd84,
    parameter logic [31:0] PASS_DATA  = 32'd7,
    parameter logic [31:0] ALLOW_ADDR = 32'd80,
    parameter int          TIMEOUT    = 1000,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [31:0]      dataadr,
    input  logic [31:0]      writedata,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] store_count,
    output logic [31:0]      cap_addr,
    output logic [31:0]      cap_data
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    localparam logic [1:0] CODE_NONE     = 2'd0;
    localparam logic [1:0] CODE_BAD_ADDR = 2'd1;
    localparam logic [1:0] CODE_BAD_DATA = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT  = 2'd3;

    // Counter value seen on the edge that completes the TIMEOUT-th RUN cycle.
    localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_fail_code;
    logic [1:0]         w_fail_code_nxt;
    logic [CNT_W-1:0]   r_cycle;
    logic [CNT_W-1:0]   r_store_count;
    logic [31:0]        r_cap_addr;
    logic [31:0]        r_cap_data;
    logic               w_in_run;
    logic               w_store_run;
    logic               w_hit_pass_addr;
    logic               w_hit_allow_addr;
    logic               w_cap_load;
    logic               w_cycle_inc;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (val == CNT_MAX) begin
            return val;
        end
        return val + 1'b1;
    endfunction

    assign w_in_run         = (r_state == ST_RUN);
    assign w_store_run      = w_in_run && memwrite;
    // The PASS_ADDR compare is tested first below, so it wins when the two
    // addresses are configured equal.
    assign w_hit_pass_addr  = (dataadr == PASS_ADDR);
    assign w_hit_allow_addr = (dataadr == ALLOW_ADDR);

    // Next-state and verdict decision; a store verdict takes precedence over timeout.
    always_comb begin
        w_state_nxt     = r_state;
        w_fail_code_nxt = r_fail_code;
        w_cap_load      = 1'b0;
        w_cycle_inc     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (memwrite && w_hit_pass_addr) begin
                    w_cap_load = 1'b1;
                    if (writedata == PASS_DATA) begin
                        w_state_nxt     = ST_PASS;
                        w_fail_code_nxt = CODE_NONE;
                    end else begin
                        w_state_nxt     = ST_FAIL;
                        w_fail_code_nxt = CODE_BAD_DATA;
                    end
                end else if (memwrite && !w_hit_allow_addr) begin
                    w_cap_load      = 1'b1;
                    w_state_nxt     = ST_FAIL;
                    w_fail_code_nxt = CODE_BAD_ADDR;
                end else if (r_cycle == CYC_LAST) begin
                    w_state_nxt     = ST_FAIL;
                    w_fail_code_nxt = CODE_TIMEOUT;
                end else begin
                    w_cycle_inc = 1'b1;
                end
            end
            ST_PASS: begin
                w_state_nxt = ST_PASS;
            end
            ST_FAIL: begin
                w_state_nxt = ST_FAIL;
            end
            default: begin
                w_state_nxt     = ST_RUN;
                w_fail_code_nxt = CODE_NONE;
            end
        endcase
    end

    // State register and fail code; PASS/FAIL hold until reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_fail_code <= CODE_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_fail_code <= w_fail_code_nxt;
        end
    end

    // RUN cycle counter, frozen once a verdict is reached.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cycle <= '0;
        end else if (w_cycle_inc) begin
            r_cycle <= r_cycle + 1'b1;
        end
    end

    // Saturating count of every store sampled in RUN, verdict store included.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_store_count <= '0;
        end else if (w_store_run) begin
            r_store_count <= sat_inc(r_store_count);
        end
    end

    // Capture of the verdict-causing store; stays zero on a timeout verdict.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cap_addr <= '0;
            r_cap_data <= '0;
        end else if (w_cap_load) begin
            r_cap_addr <= dataadr;
            r_cap_data <= writedata;
        end
    end

    assign pass        = (r_state == ST_PASS);
    assign fail        = (r_state == ST_FAIL);
    assign done        = pass | fail;
    assign fail_code   = r_fail_code;
    assign store_count = r_store_count;
    assign cap_addr    = r_cap_addr;
    assign cap_data    = r_cap_data;

endmodule
